// File: rtl/id_regfile_hazard.sv
// id_regfile_hazard: decode-stage 64x32 register file with a load-use stall/bubble FSM.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module id_regfile_hazard #(
    parameter int NUM_REGS     = 64,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_idx,
    input  logic [ADDR_W-1:0] rt_idx,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              ex_memRead,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              wb_RegWrt,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] Xrs,
    output logic [DATA_W-1:0] Xrt,
    output logic              stall,
    output logic              bubble
);
    typedef enum logic {IDLE, STALL} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en, hz, byp_rs, byp_rt;

    assign wr_en = wb_RegWrt && wb_rd != '0;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wb_rd] = wb_data;
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_rs = wr_en && wb_rd == rs_idx;
    assign byp_rt = wr_en && wb_rd == rt_idx;
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    // rst gating keeps bypassed data and hazards off the outputs while in reset
    assign Xrs = (rst || rs_idx == '0) ? '0 : byp_rs ? wb_data : regs_q[rs_idx];
    assign Xrt = (rst || rt_idx == '0) ? '0 : byp_rt ? wb_data : regs_q[rt_idx];

    assign hz = ex_memRead && ex_rd != '0 &&
                ((uses_rs && ex_rd == rs_idx) || (uses_rt && ex_rd == rt_idx));

    assign stall  = !rst && (state_q == STALL || hz);
    assign bubble = stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (hz && STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = 4'(STALL_CYCLES - 2);
            end
        end else begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_id_regfile_hazard.sv
// tb_id_regfile_hazard: randomized self-checking bench; two instances (1- and 3-cycle stalls)
// share stimulus and are compared against an array/remaining-cycles reference model.
module tb_id_regfile_hazard;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rs_idx, rt_idx, ex_rd, wb_rd;
    logic        uses_rs, uses_rt, ex_memRead, wb_RegWrt;
    logic [31:0] wb_data;
    logic [31:0] xrs1, xrt1, xrs3, xrt3;
    logic        st1, bb1, st3, bb3;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_regs [64];
    int          rem1, rem3;

    always #5 clk = ~clk;

    id_regfile_hazard #(.STALL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .rs_idx(rs_idx), .rt_idx(rt_idx), .uses_rs(uses_rs),
        .uses_rt(uses_rt), .ex_memRead(ex_memRead), .ex_rd(ex_rd), .wb_RegWrt(wb_RegWrt),
        .wb_rd(wb_rd), .wb_data(wb_data), .Xrs(xrs1), .Xrt(xrt1), .stall(st1), .bubble(bb1)
    );

    id_regfile_hazard #(.STALL_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .rs_idx(rs_idx), .rt_idx(rt_idx), .uses_rs(uses_rs),
        .uses_rt(uses_rt), .ex_memRead(ex_memRead), .ex_rd(ex_rd), .wb_RegWrt(wb_RegWrt),
        .wb_rd(wb_rd), .wb_data(wb_data), .Xrs(xrs3), .Xrt(xrt3), .stall(st3), .bubble(bb3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [5:0] idx);
        if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wb_RegWrt && wb_rd == idx) return wb_data;
`endif
        return ref_regs[idx];
    endfunction

    function automatic bit hz_m();
        return ex_memRead && ex_rd != 0 &&
               ((uses_rs && ex_rd == rs_idx) || (uses_rt && ex_rd == rt_idx));
    endfunction

    task automatic model_reset();
        foreach (ref_regs[i]) ref_regs[i] = 32'h0;
        rem1 = 0;
        rem3 = 0;
    endtask

    task automatic drive(input logic [5:0] rs, input logic [5:0] rt, input logic urs,
                         input logic urt, input logic mr, input logic [5:0] exrd,
                         input logic we, input logic [5:0] wrd, input logic [31:0] wd);
        rs_idx = rs; rt_idx = rt; uses_rs = urs; uses_rt = urt;
        ex_memRead = mr; ex_rd = exrd; wb_RegWrt = we; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic verify(input string tag);
        logic s1, s3;
        s1 = (rem1 > 0) || hz_m();
        s3 = (rem3 > 0) || hz_m();
        check({tag, ".xrs1"}, xrs1, exp_rd(rs_idx));
        check({tag, ".xrt1"}, xrt1, exp_rd(rt_idx));
        check({tag, ".xrs3"}, xrs3, exp_rd(rs_idx));
        check({tag, ".xrt3"}, xrt3, exp_rd(rt_idx));
        check({tag, ".st1"}, {31'h0, st1}, {31'h0, s1});
        check({tag, ".bb1"}, {31'h0, bb1}, {31'h0, s1});
        check({tag, ".st3"}, {31'h0, st3}, {31'h0, s3});
        check({tag, ".bb3"}, {31'h0, bb3}, {31'h0, s3});
    endtask

    // Model: a hazard seen while no stall is pending books STALL_CYCLES-1 further stall cycles.
    task automatic commit();
        bit h;
        h = hz_m();
        if (wb_RegWrt && wb_rd != 0) ref_regs[wb_rd] = wb_data;
        if (rem1 > 0) rem1--; else if (h) rem1 = 0;
        if (rem3 > 0) rem3--; else if (h) rem3 = 2;
    endtask

    task automatic cycle(input string tag, input logic [5:0] rs, input logic [5:0] rt,
                         input logic urs, input logic urt, input logic mr, input logic [5:0] exrd,
                         input logic we, input logic [5:0] wrd, input logic [31:0] wd);
        drive(rs, rt, urs, urt, mr, exrd, we, wrd, wd);
        #4;
        verify(tag);
        commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(6'd5, 6'd63, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 6'd5, 32'hFFFF_FFFF);
        #3;
        check("rst.xrs", xrs1, 32'h0);
        check("rst.xrt", xrt3, 32'h0);
        check("rst.st1", {31'h0, st1}, 32'h0);
        check("rst.bb3", {31'h0, bb3}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_edge.xrs", xrs3, 32'h0);
        rst = 1'b0;
        model_reset();

        cycle("rst_rd", 6'd5, 6'd63, 0, 0, 0, 6'd0, 0, 6'd0, 32'h0);
        cycle("wr7",    6'd0, 6'd0,  0, 0, 0, 6'd0, 1, 6'd7, 32'hDEAD_BEEF);
        cycle("rd7",    6'd7, 6'd0,  0, 0, 0, 6'd0, 0, 6'd0, 32'h0);
        cycle("wr0",    6'd0, 6'd7,  0, 0, 0, 6'd0, 1, 6'd0, 32'h0000_1234);
        cycle("rd0",    6'd0, 6'd0,  0, 0, 0, 6'd0, 0, 6'd0, 32'h0);
        cycle("byp9",   6'd7, 6'd9,  0, 0, 0, 6'd0, 1, 6'd9, 32'hA5A5_A5A5);
        cycle("aft9",   6'd7, 6'd9,  0, 0, 0, 6'd0, 0, 6'd0, 32'h0);

        cycle("lu_rs",  6'd4, 6'd1,  1, 0, 1, 6'd4, 1, 6'd3, 32'h3333_0003);
        for (int i = 0; i < 3; i++) cycle("lu_tail", 6'd3, 6'd1, 0, 0, 0, 6'd0, 0, 6'd0, 32'h0);
        cycle("lu_nouse", 6'd4, 6'd1, 0, 0, 1, 6'd4, 0, 6'd0, 32'h0);
        cycle("lu_rd0",   6'd0, 6'd0, 1, 1, 1, 6'd0, 0, 6'd0, 32'h0);
        cycle("rt_hz",  6'd2, 6'd4,  0, 1, 1, 6'd4, 0, 6'd0, 32'h0);
        for (int i = 0; i < 3; i++) cycle("rt_tail", 6'd2, 6'd4, 0, 1, 0, 6'd4, 0, 6'd0, 32'h0);
        cycle("dbl_hz", 6'd4, 6'd4,  1, 1, 1, 6'd4, 0, 6'd0, 32'h0);
        for (int i = 0; i < 3; i++) cycle("dbl_tail", 6'd4, 6'd4, 1, 1, 0, 6'd4, 0, 6'd0, 32'h0);

        cycle("ms_hz", 6'd4, 6'd1, 1, 0, 1, 6'd4, 0, 6'd0, 32'h0);
        drive(6'd7, 6'd9, 0, 0, 0, 6'd0, 0, 6'd0, 32'h0);
        #1;
        check("ms_pre.st3", {31'h0, st3}, 32'h1);
        rst = 1'b1;
        #1;
        check("ms_rst.st3", {31'h0, st3}, 32'h0);
        check("ms_rst.bb3", {31'h0, bb3}, 32'h0);
        check("ms_rst.xrs", xrs3, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle("ms_post", 6'd7, 6'd9, 0, 0, 0, 6'd0, 0, 6'd0, 32'h0);

        for (int n = 0; n < 500; n++) begin
            logic [5:0] rs, rt, erd, wrd;
            rs  = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            erd = 6'($urandom_range(0, 7));
            wrd = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            cycle("rand", rs, rt, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, erd,
                  1'($urandom), wrd, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
